pps_spi_reader: RTL and testbench

//  SPI master on the MCU side that reads the CPLD's 24-bit PPS counter through the CPLD SPI slave.

---
 rtl/pps_reader_pkg.sv | 21 ++
 rtl/pps_spi_clkgen.sv | 44 ++++
 rtl/pps_spi_reader.sv | 192 +++++++++++++++++++
 tb/tb_pps_spi_reader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pps_reader_pkg.sv
// Shared types and constants for the CPLD PPS counter SPI reader.
// The PPS_READER_DELTA_EN macro enables the count-delta outputs of pps_spi_reader.
package pps_reader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone
    } state_e;

    localparam int unsigned PPS_COUNT_W  = 24;
    localparam logic [7:0]  PPS_CMD_READ = 8'hA5;

    // Counter width that can hold the value n without wrapping.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pps_spi_clkgen.sv
// SCLK divider: CLK_DIV cycles low then CLK_DIV cycles high while enabled, idle low otherwise.
// sclk_rise_o/sclk_fall_o are single-cycle enables on the cycle whose edge changes sclk_o.
module pps_spi_clkgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic sclk_o
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;
    logic             last;

    always_comb begin
        last        = (div_q == DIV_W'(CLK_DIV - 1));
        sclk_rise_o = en_i && !phase_q && last;
        sclk_fall_o = en_i && phase_q && last;
        div_d       = '0;
        phase_d     = 1'b0;
        if (en_i) begin
            div_d   = last ? '0 : div_q + DIV_W'(1);
            phase_d = last ? ~phase_q : phase_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    assign sclk_o = phase_q;

endmodule

// File: rtl/pps_spi_reader.sv
// SPI mode-0 master that sends a command byte and reads back the CPLD PPS counter.
// Define PPS_READER_DELTA_EN to add count_delta/delta_valid (difference to the previous read).
module pps_spi_reader
    import pps_reader_pkg::*;
#(
    parameter int unsigned COUNT_W  = PPS_COUNT_W,
    parameter int unsigned CMD_W    = 8,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic               mcu_clk,
    input  logic               mcu_rst,
    input  logic               start,
    input  logic [CMD_W-1:0]   cmd,
    output logic               busy,
    output logic [COUNT_W-1:0] count_data,
    output logic               count_valid,
`ifdef PPS_READER_DELTA_EN
    output logic [COUNT_W-1:0] count_delta,
    output logic               delta_valid,
`endif
    output logic               cpld_seln,
    output logic               cpld_clk,
    output logic               cpld_sdi,
    input  logic               cpld_sdo
);

    localparam int unsigned N       = CMD_W + COUNT_W;
    localparam int unsigned CNT_W   = cnt_width(N);
    localparam int unsigned TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CMD_W-1:0]   mosi_sr_q, mosi_sr_d;
    logic               sdi_q, sdi_d;
    logic [COUNT_W-1:0] miso_sr_q, miso_sr_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic sclk_rise, sclk_fall, sclk;
    logic accept, setup_done, hold_done, last_fall, load_count;

    pps_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk_i       (mcu_clk),
        .rst_i       (mcu_rst),
        .en_i        (state_q == StShift),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .sclk_o      (sclk)
    );

    assign accept     = (state_q == StIdle) && start;
    assign setup_done = (tmr_q == TMR_W'(CS_SETUP - 1));
    assign hold_done  = (tmr_q == TMR_W'(CS_HOLD - 1));
    assign last_fall  = sclk_fall && (bit_cnt_q == CNT_W'(N - 1));
    assign load_count = (state_q == StHold) && hold_done;

    always_ff @(posedge mcu_clk) begin
        if (mcu_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start)      state_d = StSetup;
            StSetup: if (setup_done) state_d = StShift;
            StShift: if (last_fall)  state_d = StHold;
            StHold:  if (hold_done)  state_d = StDone;
            StDone:                  state_d = StIdle;
            default:                 state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = 1'b1;
        count_valid = 1'b0;
        cpld_seln   = 1'b0;
        case (state_q)
            StIdle: begin
                busy      = 1'b0;
                cpld_seln = 1'b1;
            end
            StDone: begin
                count_valid = 1'b1;
                cpld_seln   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        tmr_d     = '0;
        bit_cnt_d = bit_cnt_q;
        sdi_d     = sdi_q;
        mosi_sr_d = mosi_sr_q;
        miso_sr_d = miso_sr_q;
        count_d   = count_q;
        if ((state_q == StSetup && !setup_done) || (state_q == StHold && !hold_done)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
        if (state_q == StIdle) begin
            bit_cnt_d = '0;
        end else if (sclk_fall) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        // MOSI only moves at the start of a low phase; zeros follow the command.
        if (accept) begin
            sdi_d     = cmd[CMD_W-1];
            mosi_sr_d = cmd << 1;
        end else if (sclk_fall) begin
            sdi_d     = mosi_sr_q[CMD_W-1];
            mosi_sr_d = mosi_sr_q << 1;
        end
        if (sclk_rise && (bit_cnt_q >= CNT_W'(CMD_W))) begin
            miso_sr_d = {miso_sr_q[COUNT_W-2:0], cpld_sdo};
        end
        if (load_count) begin
            count_d = miso_sr_q;
        end
    end

    always_ff @(posedge mcu_clk) begin
        if (mcu_rst) begin
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            sdi_q     <= 1'b0;
            mosi_sr_q <= '0;
            miso_sr_q <= '0;
            count_q   <= '0;
        end else begin
            tmr_q     <= tmr_d;
            bit_cnt_q <= bit_cnt_d;
            sdi_q     <= sdi_d;
            mosi_sr_q <= mosi_sr_d;
            miso_sr_q <= miso_sr_d;
            count_q   <= count_d;
        end
    end

    assign count_data = count_q;
    assign cpld_clk   = sclk;
    assign cpld_sdi   = sdi_q;

`ifdef PPS_READER_DELTA_EN
    logic [COUNT_W-1:0] prev_q, prev_d;
    logic [COUNT_W-1:0] delta_q, delta_d;
    logic               have_prev_q, have_prev_d;
    logic               delta_ok_q, delta_ok_d;

    // The first read after reset only seeds prev; subtraction wraps modulo 2^COUNT_W.
    always_comb begin
        prev_d      = prev_q;
        delta_d     = delta_q;
        have_prev_d = have_prev_q;
        delta_ok_d  = delta_ok_q;
        if (load_count) begin
            prev_d      = miso_sr_q;
            have_prev_d = 1'b1;
            delta_ok_d  = have_prev_q;
            if (have_prev_q) begin
                delta_d = miso_sr_q - prev_q;
            end
        end
    end

    always_ff @(posedge mcu_clk) begin
        if (mcu_rst) begin
            prev_q      <= '0;
            delta_q     <= '0;
            have_prev_q <= 1'b0;
            delta_ok_q  <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            delta_q     <= delta_d;
            have_prev_q <= have_prev_d;
            delta_ok_q  <= delta_ok_d;
        end
    end

    assign count_delta = delta_q;
    assign delta_valid = count_valid && delta_ok_q;
`endif

endmodule

// File: tb/tb_pps_spi_reader.sv
// Directed bench for pps_spi_reader: default instance plus a fast-clock instance, each with a
// behavioural CPLD slave. Delta checks are built when PPS_READER_DELTA_EN is defined.
module tb_pps_spi_reader;
    import pps_reader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: default parameters
    logic        rst_a, start_a, busy_a, valid_a, seln_a, sclk_a, sdi_a;
    logic [7:0]  cmd_a;
    logic [23:0] data_a;
    logic        sdo_a = 1'b0;
`ifdef PPS_READER_DELTA_EN
    logic [23:0] delta_a;
    logic        dvalid_a;
`endif

    // Instance B: CLK_DIV=2, CS_SETUP=1, CS_HOLD=1
    logic        rst_b, start_b, busy_b, valid_b, seln_b, sclk_b, sdi_b;
    logic [7:0]  cmd_b;
    logic [23:0] data_b;
    logic        sdo_b = 1'b0;
`ifdef PPS_READER_DELTA_EN
    logic [23:0] delta_b;
    logic        dvalid_b;
`endif

    pps_spi_reader u_dut_a (
        .mcu_clk     (clk),
        .mcu_rst     (rst_a),
        .start       (start_a),
        .cmd         (cmd_a),
        .busy        (busy_a),
        .count_data  (data_a),
        .count_valid (valid_a),
`ifdef PPS_READER_DELTA_EN
        .count_delta (delta_a),
        .delta_valid (dvalid_a),
`endif
        .cpld_seln   (seln_a),
        .cpld_clk    (sclk_a),
        .cpld_sdi    (sdi_a),
        .cpld_sdo    (sdo_a)
    );

    pps_spi_reader #(
        .CLK_DIV  (2),
        .CS_SETUP (1),
        .CS_HOLD  (1)
    ) u_dut_b (
        .mcu_clk     (clk),
        .mcu_rst     (rst_b),
        .start       (start_b),
        .cmd         (cmd_b),
        .busy        (busy_b),
        .count_data  (data_b),
        .count_valid (valid_b),
`ifdef PPS_READER_DELTA_EN
        .count_delta (delta_b),
        .delta_valid (dvalid_b),
`endif
        .cpld_seln   (seln_b),
        .cpld_clk    (sclk_b),
        .cpld_sdi    (sdi_b),
        .cpld_sdo    (sdo_b)
    );

    // Slave models: 32-bit frame shifted out MSB-first, MISO changes only on SCLK falls
    logic [31:0] frame_a = '0, frame_b = '0;
    logic [31:0] mosi_a = '0, mosi_b = '0;
    int          bit_a = 0, bit_b = 0, rises_a = 0, rises_b = 0;

    always @(negedge seln_a) begin
        bit_a = 0;
        rises_a = 0;
        sdo_a = frame_a[31];
    end
    always @(negedge sclk_a) if (!seln_a) begin
        bit_a++;
        sdo_a = (bit_a < 32) ? frame_a[31 - bit_a] : 1'b0;
    end
    always @(posedge sclk_a) if (!seln_a) begin
        mosi_a = {mosi_a[30:0], sdi_a};
        rises_a++;
    end

    always @(negedge seln_b) begin
        bit_b = 0;
        rises_b = 0;
        sdo_b = frame_b[31];
    end
    always @(negedge sclk_b) if (!seln_b) begin
        bit_b++;
        sdo_b = (bit_b < 32) ? frame_b[31 - bit_b] : 1'b0;
    end
    always @(posedge sclk_b) if (!seln_b) begin
        mosi_b = {mosi_b[30:0], sdi_b};
        rises_b++;
    end

    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_data_a(input string tag);
        logic [23:0] e;
        e = 'x;
        if (exp_a.size() > 0) e = exp_a.pop_front();
        check(tag, 64'(data_a), 64'(e));
    endtask

    // Pulses start for one cycle; returns at the following negedge.
    task automatic launch_a(input logic [23:0] v, input bit expect_it);
        frame_a = {8'h00, v};
        if (expect_it) exp_a.push_back(v);
        cmd_a   = PPS_CMD_READ;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // lat counts cycles inclusively from the start cycle; 0 means timeout.
    task automatic wait_valid_a(input int budget, output int lat);
        lat = 2;
        while (!valid_a && lat <= budget) begin
            @(negedge clk);
            lat++;
        end
        if (!valid_a) lat = 0;
    endtask

    task automatic read_a(input logic [23:0] v, input string tag);
        int lat;
        launch_a(v, 1'b1);
        wait_valid_a(400, lat);
        check({tag, "_latency"}, 64'(lat), 64'(262));
        check_data_a({tag, "_data"});
    endtask

    initial begin
        int lat, nv, gaps, gap, hi, r1, r2, to;
        bit seen_low, prev;
        logic [23:0] e;

        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        cmd_a = '0; cmd_b = '0;
        repeat (3) @(negedge clk);
        check("rst_seln", 64'(seln_a), 64'(1));
        check("rst_sclk", 64'(sclk_a), 64'(0));
        check("rst_sdi", 64'(sdi_a), 64'(0));
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_data", 64'(data_a), 64'(0));
        check("rst_valid", 64'(valid_a), 64'(0));
        check("rst_b_seln", 64'(seln_b), 64'(1));
`ifdef PPS_READER_DELTA_EN
        check("rst_delta", 64'(delta_a), 64'(0));
        check("rst_dvalid", 64'(dvalid_a), 64'(0));
`endif
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Single read of 0x001234 with command 0xA5
        read_a(24'h001234, "t1");
        check("t1_mosi_cmd", 64'(mosi_a[31:24]), 64'(8'hA5));
        check("t1_mosi_tail", 64'(mosi_a[23:0]), 64'(0));
        check("t1_rises", 64'(rises_a), 64'(32));
        check("t1_busy_at_valid", 64'(busy_a), 64'(1));
        @(negedge clk);
        check("t1_busy_drop", 64'(busy_a), 64'(0));
        check("t1_valid_strobe", 64'(valid_a), 64'(0));

        // start held high across two back-to-back transactions, dropped before a third
        frame_a = {8'h00, 24'h00BEEF};
        exp_a.push_back(24'h00BEEF);
        exp_a.push_back(24'h00BEEF);
        cmd_a = 8'h3C;
        start_a = 1'b1;
        nv = 0; gaps = 0; gap = 0; hi = 0; seen_low = 1'b0;
        for (int k = 1; k <= 620; k++) begin
            @(negedge clk);
            if (valid_a) begin
                nv++;
                check_data_a("t2_data");
            end
            if (seln_a) begin
                hi++;
            end else begin
                if (seen_low && hi > 0) begin
                    gaps++;
                    gap = hi;
                end
                hi = 0;
                seen_low = 1'b1;
            end
            if (k == 520) start_a = 1'b0;
        end
        check("t2_valid_count", 64'(nv), 64'(2));
        check("t2_gap_count", 64'(gaps), 64'(1));
        check("t2_gap_len", 64'(gap), 64'(2));
        check("t2_mosi_cmd", 64'(mosi_a[31:24]), 64'(8'h3C));

        // Reset during bit 10 of the shift phase
        launch_a(24'h123456, 1'b0);
        to = 0;
        while (rises_a < 11 && to < 400) begin
            @(negedge clk);
            to++;
        end
        check("t3_reached_bit10", 64'(rises_a), 64'(11));
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("t3_seln", 64'(seln_a), 64'(1));
        check("t3_sclk", 64'(sclk_a), 64'(0));
        check("t3_busy", 64'(busy_a), 64'(0));
        check("t3_data_cleared", 64'(data_a), 64'(0));
        nv = 0;
        repeat (300) begin
            @(negedge clk);
            if (valid_a) nv++;
        end
        check("t3_no_valid", 64'(nv), 64'(0));
        read_a(24'hABCDEF, "t3_after");
`ifdef PPS_READER_DELTA_EN
        check("t3_first_no_delta", 64'(dvalid_a), 64'(0));

        // Delta across counter wrap, then equal reads
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("t4_delta_rst", 64'(delta_a), 64'(0));
        read_a(24'hFFFFFE, "t4_r1");
        check("t4_r1_no_dvalid", 64'(dvalid_a), 64'(0));
        read_a(24'h000003, "t4_r2");
        check("t4_r2_dvalid", 64'(dvalid_a), 64'(1));
        check("t4_r2_delta", 64'(delta_a), 64'(24'h000005));
        read_a(24'h000010, "t5_r1");
        check("t5_r1_delta", 64'(delta_a), 64'(24'h00000D));
        read_a(24'h000010, "t5_r2");
        check("t5_r2_dvalid", 64'(dvalid_a), 64'(1));
        check("t5_r2_delta", 64'(delta_a), 64'(0));
        @(negedge clk);
        check("t5_dvalid_strobe", 64'(dvalid_a), 64'(0));
`endif

        // Fast instance: SCLK period 4, alternating data exposes off-edge sampling
        frame_b = {8'h00, 24'h5A5A5A};
        exp_b.push_back(24'h5A5A5A);
        cmd_b = 8'hC3;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat = 2; prev = 1'b0; r1 = 0; r2 = 0;
        while (!valid_b && lat <= 300) begin
            if (sclk_b && !prev) begin
                if (r1 == 0) r1 = lat;
                else if (r2 == 0) r2 = lat;
            end
            prev = sclk_b;
            @(negedge clk);
            lat++;
        end
        if (!valid_b) lat = 0;
        check("t6_latency", 64'(lat), 64'(132));
        check("t6_sclk_period", 64'(r2 - r1), 64'(4));
        e = 'x;
        if (exp_b.size() > 0) e = exp_b.pop_front();
        check("t6_data", 64'(data_b), 64'(e));
        check("t6_mosi_cmd", 64'(mosi_b[31:24]), 64'(8'hC3));
        check("t6_rises", 64'(rises_b), 64'(32));

        check("scoreboard_a_empty", 64'(exp_a.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
